// File: rtl/rep3_pkg.sv
// Shared types and constants for the triple-repetition serial link.
// Every frame bit is sent as REP identical chips so the receiver can take a 2-of-3 majority vote.
package rep3_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam int   REP       = 3;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Counter width that never collapses to zero bits for a modulus of 1.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rep3_chip_timer.sv
// Chip timer: counts clk cycles while a frame is active and strobes chip_end on the last cycle of each chip.
module rep3_chip_timer
    import rep3_pkg::*;
#(
    parameter int CLKS_PER_CHIP = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic chip_end
);

    localparam int CW = cnt_w(CLKS_PER_CHIP);

    logic [CW-1:0] chip_cnt;

    assign chip_end = en && (chip_cnt == CW'(CLKS_PER_CHIP - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chip_cnt <= '0;
        end else if (clr || chip_end) begin
            chip_cnt <= '0;
        end else if (en) begin
            chip_cnt <= chip_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/rep3_serial_tx.sv
// Transmit side of the triple-repetition serial link: frames each accepted word as start, data LSB-first, stop.
// Every frame bit goes out as REP chips. tx_out comes straight from a flop, so the line never glitches.
//
// state | meaning
// IDLE  | line high, ready_out=1, waiting for valid_in
// START | sending start bit (0) as REP chips
// DATA  | sending shift_q[0] as REP chips, DATA_W bits LSB first
// STOP  | sending stop bit (1) as REP chips; goes to IDLE and pulses done
module rep3_serial_tx
    import rep3_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int CLKS_PER_CHIP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              tx_out,
    output logic              busy,
    output logic              done
);

    localparam int BW = cnt_w(DATA_W);

    state_t            state, state_n;
    logic [1:0]        rep_cnt, rep_cnt_n;
    logic [BW-1:0]     bit_cnt, bit_cnt_n;
    logic [DATA_W-1:0] shift_q, shift_n;
    logic              tx_q, tx_n;
    logic              done_q, done_n;
    logic              accept;
    logic              chip_end;
    logic              rep_end;

    assign busy      = (state != IDLE);
    assign ready_out = (state == IDLE);
    assign accept    = valid_in && ready_out;
    assign rep_end   = chip_end && (rep_cnt == 2'(REP - 1));
    assign tx_out    = tx_q;
    assign done      = done_q;

    rep3_chip_timer #(
        .CLKS_PER_CHIP(CLKS_PER_CHIP)
    ) u_chip_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (busy),
        .clr     (accept),
        .chip_end(chip_end)
    );

    always_comb begin
        state_n   = state;
        rep_cnt_n = rep_cnt;
        bit_cnt_n = bit_cnt;
        shift_n   = shift_q;
        done_n    = 1'b0;
        tx_n      = STOP_BIT;

        if (chip_end) begin
            rep_cnt_n = rep_end ? 2'd0 : rep_cnt + 2'd1;
        end

        case (state)
            IDLE: begin
                if (accept) begin
                    state_n   = START;
                    shift_n   = data_in;
                    rep_cnt_n = 2'd0;
                    bit_cnt_n = '0;
                end
            end
            START: begin
                if (rep_end) state_n = DATA;
            end
            DATA: begin
                if (rep_end) begin
                    shift_n = shift_q >> 1;
                    if (bit_cnt == BW'(DATA_W - 1)) begin
                        bit_cnt_n = '0;
                        state_n   = STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + BW'(1);
                    end
                end
            end
            STOP: begin
                if (rep_end) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Line value for the coming cycle, so tx_out lines up with the state it belongs to.
        case (state_n)
            START:   tx_n = START_BIT;
            DATA:    tx_n = shift_n[0];
            default: tx_n = STOP_BIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rep_cnt <= 2'd0;
            bit_cnt <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            rep_cnt <= rep_cnt_n;
            bit_cnt <= bit_cnt_n;
            shift_q <= shift_n;
            tx_q    <= tx_n;
            done_q  <= done_n;
        end
    end

endmodule

// File: tb/tb_rep3_serial_tx.sv
// Bench for rep3_serial_tx: one DUT with 1-cycle chips and one with 4-cycle chips.
// Line monitors sample the line, decode frames by majority vote and score them against the words that were sent.
module tb_rep3_serial_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data1, data4;
    logic       valid1, valid4;
    logic       ready1, tx1, busy1, done1;
    logic       ready4, tx4, busy4, done4;

    always #5 clk = ~clk;

    rep3_serial_tx #(.DATA_W(8), .CLKS_PER_CHIP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .data_in(data1), .valid_in(valid1),
        .ready_out(ready1), .tx_out(tx1), .busy(busy1), .done(done1)
    );

    rep3_serial_tx #(.DATA_W(8), .CLKS_PER_CHIP(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .data_in(data4), .valid_in(valid4),
        .ready_out(ready4), .tx_out(tx4), .busy(busy4), .done(done4)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    logic [7:0] q1[$];
    logic [7:0] q4[$];
    bit         flip_en = 1'b0;
    int         frames1 = 0;
    int         frames4 = 0;

    typedef logic samp_t [0:119];

    // Majority-vote decode of a 10-bit frame from per-cycle line samples.
    task automatic decode(input samp_t s, input int cpc, output logic [9:0] frame_bits,
                          output int hold_bad, output int split);
        logic [2:0] c;
        hold_bad = 0;
        split    = 0;
        for (int b = 0; b < 10; b++) begin
            for (int r = 0; r < 3; r++) begin
                int base;
                base = (b * 3 + r) * cpc;
                c[r] = s[base];
                for (int j = 1; j < cpc; j++)
                    if (s[base + j] !== s[base]) hold_bad++;
            end
            frame_bits[b] = (c[0] & c[1]) | (c[0] & c[2]) | (c[1] & c[2]);
            if (!(c == 3'b000 || c == 3'b111)) split++;
        end
    endtask

    samp_t      s1;
    logic       prev1 = 1'b0;
    bit         ab1;
    logic [9:0] fb1;
    int         hb1, sp1, fp1;
    logic [7:0] e1;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && busy1 === 1'b1 && prev1 !== 1'b1) begin
                ab1 = 1'b0;
                for (int c = 0; c < 30; c++) begin
                    if (c > 0) @(negedge clk);
                    if (rst_n !== 1'b1) begin
                        ab1 = 1'b1;
                        break;
                    end
                    if (c % 3 == 0) fp1 = $urandom_range(0, 2);
                    s1[c] = tx1 ^ (flip_en && (c % 3 == fp1));
                end
                if (ab1) begin
                    if (q1.size() > 0) e1 = q1.pop_front();
                    prev1 = 1'b0;
                    continue;
                end
                @(negedge clk);
                chk("post_done1", done1, 1);
                chk("post_busy1", busy1, 0);
                chk("post_tx1", tx1, 1);
                frames1++;
                decode(s1, 1, fb1, hb1, sp1);
                chk("sb1_depth", q1.size(), 1);
                if (q1.size() > 0) begin
                    e1 = q1.pop_front();
                    chk("start1", fb1[0], 0);
                    chk("stop1", fb1[9], 1);
                    chk("data1", fb1[8:1], e1);
                    if (!flip_en) chk("unanimous1", sp1, 0);
                end
            end
            prev1 = busy1;
        end
    end

    samp_t      s4;
    logic       prev4 = 1'b0;
    bit         ab4;
    logic [9:0] fb4;
    int         hb4, sp4;
    logic [7:0] e4;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && busy4 === 1'b1 && prev4 !== 1'b1) begin
                ab4 = 1'b0;
                for (int c = 0; c < 120; c++) begin
                    if (c > 0) @(negedge clk);
                    if (rst_n !== 1'b1) begin
                        ab4 = 1'b1;
                        break;
                    end
                    s4[c] = tx4;
                end
                if (ab4) begin
                    if (q4.size() > 0) e4 = q4.pop_front();
                    prev4 = 1'b0;
                    continue;
                end
                @(negedge clk);
                chk("post_done4", done4, 1);
                chk("post_busy4", busy4, 0);
                chk("post_tx4", tx4, 1);
                frames4++;
                decode(s4, 4, fb4, hb4, sp4);
                chk("sb4_depth", q4.size(), 1);
                if (q4.size() > 0) begin
                    e4 = q4.pop_front();
                    chk("start4", fb4[0], 0);
                    chk("stop4", fb4[9], 1);
                    chk("data4", fb4[8:1], e4);
                    chk("hold4", hb4, 0);
                    chk("unanimous4", sp4, 0);
                end
            end
            prev4 = busy4;
        end
    end

    task automatic send1(input logic [7:0] d, input bit hold, output bit was_done);
        int n;
        n = 0;
        was_done = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (ready1 !== 1'b1 && n < 400);
        chk("send1_ready", ready1, 1);
        if (ready1 !== 1'b1) return;
        data1    = d;
        valid1   = 1'b1;
        was_done = done1;
        @(posedge clk);
        q1.push_back(d);
        #1;
        if (!hold) valid1 = 1'b0;
    endtask

    task automatic wait_idle1();
        int n;
        n = 0;
        while ((busy1 !== 1'b0 || done1 !== 1'b0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("idle1_timeout", busy1, 0);
        repeat (2) @(negedge clk);
    endtask

    bit wd;
    int n;
    int done_seen;

    initial begin
        rst_n  = 1'b1;
        valid1 = 1'b0;
        valid4 = 1'b0;
        data1  = '0;
        data4  = '0;

        // Reset asserted between edges: outputs must settle with no clock edge yet.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_tx1", tx1, 1);
        chk("rst_ready1", ready1, 1);
        chk("rst_busy1", busy1, 0);
        chk("rst_done1", done1, 0);
        chk("rst_tx4", tx4, 1);
        repeat (3) @(negedge clk);
        chk("rst_hold_tx1", tx1, 1);
        chk("rst_hold_ready4", ready4, 1);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_tx1", tx1, 1);
        chk("idle_done1", done1, 0);

        // Single word, exact latency and frame length.
        send1(8'hA5, 1'b0, wd);
        @(negedge clk);
        chk("lat_tx1", tx1, 0);
        chk("lat_busy1", busy1, 1);
        chk("lat_ready1", ready1, 0);
        n = 1;
        while (done1 !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("done_cycle1", n, 31);
        wait_idle1();

        // Back-to-back with valid held high.
        send1(8'h00, 1'b1, wd);
        send1(8'hFF, 1'b0, wd);
        chk("b2b_accept_in_done", wd, 1);
        @(negedge clk);
        chk("b2b_start_tx", tx1, 0);
        wait_idle1();

        // Loopback with one chip flipped per triple.
        flip_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            send1(8'($urandom_range(0, 255)), 1'b0, wd);
        end
        wait_idle1();
        flip_en = 1'b0;

        // Reset mid-frame at chip 12 (data bit 3 of 0x52 is 0, so the line is low there).
        send1(8'h52, 1'b0, wd);
        repeat (13) @(negedge clk);
        chk("pre_rst_tx1", tx1, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_tx1", tx1, 1);
        chk("midrst_busy1", busy1, 0);
        chk("midrst_ready1", ready1, 1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done1 === 1'b1) done_seen++;
        end
        chk("midrst_no_done", done_seen, 0);
        send1(8'h3C, 1'b0, wd);
        wait_idle1();

        // Four-cycle chips, with valid/data churn during the frame.
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ready4 !== 1'b1 && n < 400);
        chk("send4_ready", ready4, 1);
        data4  = 8'h81;
        valid4 = 1'b1;
        @(posedge clk);
        q4.push_back(8'h81);
        #1 valid4 = 1'b0;
        n = 0;
        while (n < 130) begin
            @(negedge clk);
            n++;
            if (done4 === 1'b1) break;
            if (n <= 100) begin
                valid4 = 1'($urandom_range(0, 1));
                data4  = 8'($urandom_range(0, 255));
            end else begin
                valid4 = 1'b0;
            end
        end
        valid4 = 1'b0;
        chk("done_cycle4", n, 121);
        repeat (5) @(negedge clk);

        chk("frames1", frames1, 260);
        chk("frames4", frames4, 1);
        chk("q1_left", q1.size(), 0);
        chk("q4_left", q4.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
